// File: rtl/ram_pkg.sv
// Shared types, default sizes and the fixed command table
// for the self-sequencing RAM block.
package ram_pkg;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_ADDR_WIDTH = 4;
    localparam int DEF_NUM_STEPS  = 8;

    typedef enum logic {
        OP_READ  = 1'b0,
        OP_WRITE = 1'b1
    } op_e;

    typedef struct packed {
        op_e                       op;
        logic [DEF_ADDR_WIDTH-1:0] addr;
        logic [DEF_DATA_WIDTH-1:0] wdata;
    } cmd_t;

    localparam cmd_t CMD_TABLE [DEF_NUM_STEPS] = '{
        '{OP_READ,  4'd3,  8'h00},
        '{OP_WRITE, 4'd3,  8'hA5},
        '{OP_READ,  4'd3,  8'h00},
        '{OP_WRITE, 4'd7,  8'h3C},
        '{OP_READ,  4'd7,  8'h00},
        '{OP_READ,  4'd0,  8'h00},
        '{OP_WRITE, 4'd15, 8'hFF},
        '{OP_READ,  4'd15, 8'h00}
    };

    // Larger step counts simply cycle through the table again.
    function automatic cmd_t cmd_at(input int idx);
        return CMD_TABLE[idx % DEF_NUM_STEPS];
    endfunction

endpackage

// File: rtl/ram_array.sv
// Storage array: combinational read, synchronous write,
// reset loads each word with its own index.
module ram_array
    import ram_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= DATA_WIDTH'(i);
            end
        end else if (we) begin
            mem[addr] <= wdata;
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/ram.sv
// Top level: steps through the command table one entry per
// clock and registers each command's result on ram_out.
module ram
    import ram_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int NUM_STEPS  = DEF_NUM_STEPS
) (
    input  logic                  clock,
    input  logic                  reset,
    output logic [DATA_WIDTH-1:0] ram_out
);

    localparam int STEP_W = (NUM_STEPS > 1) ? $clog2(NUM_STEPS) : 1;

    logic [STEP_W-1:0]     step;
    cmd_t                  cmd;
    logic                  we;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
    logic [DATA_WIDTH-1:0] rdata;

    always_comb begin
        cmd   = cmd_at(int'(step));
        we    = (cmd.op == OP_WRITE);
        addr  = ADDR_WIDTH'(cmd.addr);
        wdata = DATA_WIDTH'(cmd.wdata);
    end

    ram_array #(
        .DATA_WIDTH(DATA_WIDTH),
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_array (
        .clock(clock),
        .reset(reset),
        .we   (we),
        .addr (addr),
        .wdata(wdata),
        .rdata(rdata)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            step <= '0;
        end else if (step == STEP_W'(NUM_STEPS - 1)) begin
            step <= '0;
        end else begin
            step <= step + STEP_W'(1);
        end
    end

    // rdata still holds the pre-edge word, so a read sees old contents.
    always_ff @(posedge clock) begin
        if (reset) begin
            ram_out <= '0;
        end else if (we) begin
            ram_out <= wdata;
        end else begin
            ram_out <= rdata;
        end
    end

endmodule

// File: tb/tb_ram.sv
// Scoreboard bench for ram: a behavioural model and directed
// expectations feed queues that a negedge monitor drains.
`timescale 1ns/1ps
module tb_ram;

    logic       clock;
    logic       reset;
    logic [7:0] ram_out;

    ram dut (
        .clock  (clock),
        .reset  (reset),
        .ram_out(ram_out)
    );

    realtime half = 5.0;
    initial clock = 1'b0;
    always #(half) clock = ~clock;

    typedef struct {
        int         tag;
        logic [7:0] val;
    } exp_t;

    exp_t exp_q [$];
    exp_t dir_q [$];

    int checks   = 0;
    int failures = 0;
    int edge_n   = 0;
    bit started  = 0;

    // Reference behaviour: table as plain arrays, memory as a byte array.
    bit         t_wr [8] = '{0, 1, 0, 1, 0, 0, 1, 0};
    int         t_ad [8] = '{3, 3, 3, 7, 7, 0, 15, 15};
    logic [7:0] t_wd [8] = '{8'h00, 8'hA5, 8'h00, 8'h3C,
                             8'h00, 8'h00, 8'hFF, 8'h00};
    logic [7:0] m_mem [16];
    int         m_step;
    logic [7:0] m_out;

    task automatic model_edge();
        edge_n++;
        if (reset) begin
            for (int i = 0; i < 16; i++) m_mem[i] = 8'(i);
            m_step  = 0;
            m_out   = 8'h00;
            started = 1;
        end else if (started) begin
            if (t_wr[m_step]) begin
                m_mem[t_ad[m_step]] = t_wd[m_step];
                m_out = t_wd[m_step];
            end else begin
                m_out = m_mem[t_ad[m_step]];
            end
            m_step = (m_step + 1) % 8;
        end
        if (started) exp_q.push_back('{edge_n, m_out});
    endtask

    initial forever begin
        @(posedge clock);
        model_edge();
    end

    task automatic check(input string name, input int tag,
                         input logic [7:0] want);
        checks++;
        if (ram_out !== want) begin
            failures++;
            $display("FAIL %s edge=%0d got=%h want=%h",
                     name, tag, ram_out, want);
        end
    endtask

    initial forever begin
        exp_t e;
        @(negedge clock);
        while (exp_q.size() > 0 && exp_q[0].tag <= edge_n) begin
            e = exp_q.pop_front();
            check("model", e.tag, e.val);
        end
        while (dir_q.size() > 0 && dir_q[0].tag <= edge_n) begin
            e = dir_q.pop_front();
            check("directed", e.tag, e.val);
        end
    end

    task automatic dir_edge(input logic r, input logic [7:0] v);
        reset = r;
        dir_q.push_back('{edge_n + 1, v});
        @(negedge clock);
    endtask

    task automatic check_step0(input string name);
        checks++;
        if (dut.step !== 3'd0) begin
            failures++;
            $display("FAIL %s got=%0d want=0", name, dut.step);
        end
    endtask

    logic [7:0] seq [10] = '{8'h03, 8'hA5, 8'hA5, 8'h3C, 8'h3C,
                             8'h00, 8'hFF, 8'hFF, 8'hA5, 8'hA5};

    initial begin
        reset = 1'b0;
        repeat (2) @(negedge clock);

        dir_edge(1'b1, 8'h00);
        dir_edge(1'b1, 8'h00);
        check_step0("reset_step");

        // Full pass plus wrap into the second pass.
        for (int i = 0; i < 10; i++) dir_edge(1'b0, seq[i]);

        // Reset mid-sequence after four commands.
        dir_edge(1'b1, 8'h00);
        for (int i = 0; i < 4; i++) dir_edge(1'b0, seq[i]);
        dir_edge(1'b1, 8'h00);
        for (int i = 0; i < 2; i++) dir_edge(1'b0, seq[i]);

        // Long reset hold: output and memory stay at reset values.
        for (int i = 0; i < 5; i++) dir_edge(1'b1, 8'h00);
        check_step0("hold_step");
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (dut.u_array.mem[i] !== 8'(i)) begin
                failures++;
                $display("FAIL hold_mem[%0d] got=%h want=%h",
                         i, dut.u_array.mem[i], 8'(i));
            end
        end

        // Fast free-run at a 100 ps period.
        half = 0.05;
        for (int i = 0; i < 10; i++) dir_edge(1'b0, seq[i]);
        half = 5.0;
        @(negedge clock);

        // Random reset pulses; the model tracks every edge.
        for (int i = 0; i < 300; i++) begin
            reset = ($urandom_range(0, 15) == 0);
            @(negedge clock);
        end
        reset = 1'b0;
        repeat (3) @(negedge clock);

        checks++;
        if (dir_q.size() != 0 || exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain dir=%0d exp=%0d want=0",
                     dir_q.size(), exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ram.md
RAM -- requirements
Module: ram

Interface
REQ-001 Parameter DATA_WIDTH, default 8, word width in bits.
REQ-002 Parameter ADDR_WIDTH, default 4, address width in bits; DEPTH = 2**ADDR_WIDTH = 16 words.
REQ-003 Parameter NUM_STEPS, default 8, number of entries in the internal command table.
REQ-004 Port clock  input  1  sole clock; all state changes on its rising edge.
REQ-005 Port reset  input  1  synchronous, active-high reset.
REQ-006 Port ram_out  output  DATA_WIDTH  registered result of the most recently executed command.
REQ-007 The block SHALL have one clock; reset SHALL be synchronous and active-high.

Function
REQ-008 The block SHALL contain a DEPTH x DATA_WIDTH storage array with no external address, data or enable ports; all accesses come from an internal fixed command table.
REQ-009 Each command SHALL hold op (READ or WRITE), addr (ADDR_WIDTH bits) and wdata (DATA_WIDTH bits).
REQ-010 The command table SHALL be, step 0..7: READ 3; WRITE 3,0xA5; READ 3; WRITE 7,0x3C; READ 7; READ 0; WRITE 15,0xFF; READ 15.
REQ-011 A step counter, width clog2(NUM_STEPS), SHALL select the current command.
REQ-012 On each rising edge with reset low, the block SHALL execute the current command and advance the step counter by 1.
REQ-013 READ SHALL load ram_out with mem[addr] as held before that edge.
REQ-014 WRITE SHALL store wdata into mem[addr] and SHALL load ram_out with wdata on the same edge (write-through).
REQ-015 Latency SHALL be one cycle: ram_out reflects command N after the Nth rising edge following reset release.
REQ-016 After step NUM_STEPS-1 the counter SHALL wrap to 0; memory contents SHALL persist across the wrap, so the second pass's step 0 returns 0xA5.
REQ-017 Only one command SHALL execute per cycle, so no read/write collision is possible.
REQ-018 ram_out SHALL be driven directly from a register, with no combinational path from storage.

Reset
REQ-019 When reset is high at a rising edge, step SHALL be set to 0 and ram_out to 0x00.
REQ-020 When reset is high at a rising edge, mem[i] SHALL be set to i for all i in 0..15, i.e. 0x00..0x0F.
REQ-021 Reset SHALL take priority over command execution, including a reset asserted mid-sequence.
REQ-022 Before the first reset, ram_out and memory contents are don't-care.

Structure
REQ-023 Package ram_pkg SHALL hold the op enum (OP_READ, OP_WRITE), the command struct typedef, the default parameter constants and the constant command table.
REQ-024 Storage SHALL be a sub-module ram_array with clock, reset, write enable, address, write data and read data ports, and reset-to-index initialisation.
REQ-025 Top-level ram SHALL hold the step counter, the command decode and the ram_out register.

Verification
REQ-026 Assert reset for 2 cycles -> ram_out = 0x00 and step = 0.
REQ-027 Release reset and run 8 edges -> ram_out sequence 0x03, 0xA5, 0xA5, 0x3C, 0x3C, 0x00, 0xFF, 0xFF.
REQ-028 Run edges 9 and 10 (wrap) -> ram_out 0xA5 (READ 3), then 0xA5 (WRITE 3).
REQ-029 Assert reset after edge 4, then release -> next edges give 0x03, 0xA5, confirming memory and step were reinitialised.
REQ-030 Hold reset high for 5 edges -> ram_out stays 0x00 and no memory location changes.
REQ-031 Free-run 10 cycles at a 100 ps period after one reset, then stop at 2 ns -> no X on ram_out after the first post-reset edge.
